// File: rtl/dmem_access_unit.sv
// RV32I data-memory responder: byte/half/word loads and stores against an
// internal byte-lane word RAM, with a busy/done handshake toward the core.
module dmem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_en,
    input  logic        dm_rw,
    input  logic [1:0]  enloadsize,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);
    localparam int AW    = ADDR_W + 2;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [3:0][7:0]   mem [DEPTH];
    logic [31:0]       rd_word_q;

    logic              misalign, out_of_range, accept;
    logic [31:0]       shifted, load_ext;
    logic [3:0]        be;
    logic [3:0][7:0]   wlane;
    logic              we;
    logic [ADDR_W-1:0] widx;

    assign misalign     = ((enloadsize == 2'b01) && addr[0]) ||
                          (enloadsize[1] && (addr[1:0] != 2'b00));
    assign out_of_range = (addr[31:AW] != '0);
    assign accept       = (state_q == IDLE) && dm_en;

    // Loaded lane(s) moved down to bit 0, then extended by size.
    assign shifted = rd_word_q >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = rd_word_q;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = rd_word_q;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wlane = wdata_q;
        case (size_q)
            2'b00: begin
                be    = 4'b0001 << addr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    // Reset forces IDLE asynchronously, which also drops the pending write.
    assign we   = (state_q == ACCESS) && rw_q;
    assign widx = addr_q[AW-1:2];

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        case (state_q)
            IDLE: begin
                if (dm_en) begin
                    rw_d    = dm_rw;
                    size_d  = enloadsize;
                    uns_d   = ld_unsigned;
                    addr_d  = addr[AW-1:0];
                    wdata_d = wdata;
                    if (misalign || out_of_range) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                done_d  = 1'b1;
                if (!rw_q) rdata_d = load_ext;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is not reset; the word read is registered at acceptance so the
    // array maps onto a synchronous-read block RAM.
    always_ff @(posedge clk) begin
        if (accept) rd_word_q <= mem[addr[AW-1:2]];
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) mem[widx][i] <= wlane[i];
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign rdata = rdata_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed cases plus random traffic
// compared against a byte-addressed reference memory.
module tb_dmem_access_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dm_en = 1'b0;
    logic        dm_rw = 1'b0;
    logic [1:0]  enloadsize = 2'b00;
    logic        ld_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [0:4095];
    logic [31:0] last_rd;
    logic        last_err;

    dmem_access_unit #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .dm_en(dm_en), .dm_rw(dm_rw),
        .enloadsize(enloadsize), .ld_unsigned(ld_unsigned),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One full transaction; entered and left on a negedge.
    task automatic run(input bit rw, input bit [1:0] sz, input bit uns,
                       input bit [31:0] a, input bit [31:0] wd);
        int n, lat, bc;
        bit exp_err;
        logic [31:0] v, mask;
        n       = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_err = ((a % n) != 0) || (a >= 32'd4096);
        mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = 32'h0;
        if (!rw && !exp_err) begin
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
            if (!uns && v[8 * n - 1]) v = v | ~mask;
        end
        dm_en = 1'b1; dm_rw = rw; enloadsize = sz; ld_unsigned = uns;
        addr = a; wdata = wd;
        @(posedge clk);
        @(negedge clk);
        dm_en = 1'b0; dm_rw = $urandom; addr = $urandom; wdata = $urandom;
        lat = 1; bc = 0;
        while (!done && lat < 6) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
        if (busy) bc++;
        last_rd  = rdata;
        last_err = err;
        chk("latency", lat, exp_err ? 1 : 2);
        chk("err", err, exp_err);
        chk("rdata", rdata, v);
        chk("busy_cycles", bc, exp_err ? 1 : 2);
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        if (rw && !exp_err)
            for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8 * i +: 8];
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Give the random-traffic region defined contents.
        for (int w = 0; w < 64; w++) run(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom);

        run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("dir_word", last_rd, 32'hDEAD_BEEF);
        run(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("dir_lb", last_rd, 32'hFFFF_FFDE);
        run(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        chk("dir_lbu", last_rd, 32'h0000_00DE);
        run(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
        run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("dir_sh", last_rd, 32'h1234_BEEF);
        run(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0077);
        run(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        chk("dir_sb", last_rd, 32'h1234_BE77);
        run(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        chk("dir_mis_err", last_err, 1'b1);
        chk("dir_mis_rd", last_rd, 32'h0);
        run(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        v0_check: begin
            logic [31:0] w0;
            w0 = last_rd;
            run(1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hCAFE_F00D);
            chk("dir_oor_err", last_err, 1'b1);
            run(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
            chk("dir_oor_w0", last_rd, w0);
        end

        // Reset pulsed while a store sits in ACCESS.
        run(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAA_AAAA);
        dm_en = 1'b1; dm_rw = 1'b1; enloadsize = 2'b10; addr = 32'h20;
        wdata = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        dm_en = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 4; i++) begin
                if (done) seen++;
                @(negedge clk);
            end
            chk("arst_no_done", seen, 0);
        end
        run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("arst_keep", last_rd, 32'hAAAA_AAAA);

        for (int k = 0; k < 250; k++) begin
            bit [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = $urandom_range(0, 255);
            else if (sel == 8) a = 32'h1000 | ($urandom & 32'hFF);
            else               a = $urandom;
            run(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
